// File: rtl/lut4_inv_rv32.sv
// Builds the inverse of a 4-bit S-box held as 16 nibbles in two XLEN words, and flags non-bijective S-boxes.
// Define LUT4_INV_DUAL_EN to process two table entries per cycle; the results are unchanged.
module lut4_inv_rv32 #(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] rd_lo,
  output logic [XLEN-1:0] rd_hi,
  output logic            err
);

`ifdef LUT4_INV_DUAL_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   src_q, src_d;
  logic [2*XLEN-1:0]   tbl_q, tbl_d;
  logic [15:0]         seen_q, seen_d;
  logic                err_q, err_d;
  logic [3:0]          k_a, v_a;
`ifdef LUT4_INV_DUAL_EN
  logic [3:0]          k_b, v_b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    tbl_d   = tbl_q;
    seen_d  = seen_q;
    err_d   = err_q;
`ifdef LUT4_INV_DUAL_EN
    k_a     = {cnt_q, 1'b0};
    k_b     = {cnt_q, 1'b1};
    v_b     = src_q[{k_b, 2'b00} +: 4];
`else
    k_a     = cnt_q;
`endif
    v_a     = src_q[{k_a, 2'b00} +: 4];
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          src_d   = {rs2, rs1};
          tbl_d   = '0;
          seen_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        tbl_d[{v_a, 2'b00} +: 4] = k_a;
        seen_d[v_a]              = 1'b1;
`ifdef LUT4_INV_DUAL_EN
        // The odd step is applied second so a same-cycle collision keeps the higher index.
        tbl_d[{v_b, 2'b00} +: 4] = k_b;
        seen_d[v_b]              = 1'b1;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          err_d   = ~&seen_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (o_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      tbl_q   <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      tbl_q   <= tbl_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign rd_lo   = tbl_q[XLEN-1:0];
  assign rd_hi   = tbl_q[2*XLEN-1:XLEN];
  assign err     = err_q;

endmodule
